pulse_train_generator: RTL and testbench
========================================

# pulse_train_generator

Runtime-programmable successor to the fixed-parameter pulse generator. It emits a train of periodic pulses whose cycle count, cycle length, pulse width and in-cycle delay are loaded from input ports at each start, rather than fixed at elaboration. It adds abort, busy/cycle-tick status, configuration checking and an optional continuous mode. It sits next to the bus-emulation FSMs, driving clock/strobe lines toward the target device.

## Interface
- `CNT_WIDTH`, 16: width of `cfg_cycle_count`.
- `LEN_WIDTH`, 16: width of `cfg_cycle_len`, `cfg_pulse_len`, `cfg_delay`.
- `ACTIVE_LOW`, 0: 0 means passive level 0 and pulse level 1; 1 inverts both.

Ports (one clock; reset is synchronous and active-high):
- `sys_clk` in 1: system clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a train; sampled only in IDLE.
- `stop` in 1: abort the train; sampled only in RUN.
- `cfg_cycle_count` in CNT_WIDTH: number of cycles.
- `cfg_cycle_len` in LEN_WIDTH: cycle length in sys_clk cycles.
- `cfg_pulse_len` in LEN_WIDTH: pulse width in sys_clk cycles.
- `cfg_delay` in LEN_WIDTH: offset of the pulse from the start of the cycle.
- `out_sig` out 1: registered pulse output.
- `cycle_tick` out 1: one-cycle strobe at the end of every cycle.
- `busy` out 1: high in RUN.
- `done_sig` out 1: level, high when idle and ready.
- `cfg_err` out 1: one-cycle strobe when a start is rejected.

## Operation
- States: RESET, IDLE, RUN.
- **Reset.** `rst` has highest priority. On an edge with `rst`=1:
  - state goes to RESET;
  - `out_sig` goes passive;
  - `busy`, `done_sig`, `cycle_tick`, `cfg_err` go to 0.
- **RESET.** On the next edge: clear `cycle_ctr`/`pulse_ctr`, set `done_sig`=1, go to IDLE.
- **IDLE, start sampled.** On `start`=1, latch all four cfg inputs into shadow registers and validate them:
  - Invalid if `cycle_len`==0, or `delay+pulse_len` > `cycle_len`. The sum is computed in LEN_WIDTH+1 bits, with no wrap.
  - Invalid if `cycle_count`==0, unless continuous mode is compiled in.
  - Invalid: pulse `cfg_err` for one cycle, stay IDLE, keep `done_sig`=1.
  - Valid: go to RUN, `busy`=1, `done_sig`=0, counters at 0.
- **IDLE, other inputs.** `stop` in IDLE is ignored. `start` together with `stop` in IDLE starts normally.
- **RUN, each edge.** All checks use the pre-edge `pulse_ctr`=p.
  - `out_sig` is active iff `delay` ≤ p < `delay+pulse_len`; otherwise passive.
  - If p == `cycle_len-1`: `pulse_ctr` goes to 0, `cycle_ctr` increments, and `cycle_tick` is 1 for that cycle. Otherwise `pulse_ctr` increments.
- **RUN, completion.** When `cycle_ctr` == latched `cycle_count`:
  - `out_sig` goes passive and counters clear;
  - `busy`=0, `done_sig`=1, go to IDLE.
- **RUN, abort.** `stop`=1 in RUN, with priority over counting:
  - same actions as completion on that edge;
  - `cycle_tick` is 0.
- **RUN, other inputs.** `start` is ignored; cfg input changes are ignored because the shadow registers are used.
- **Zero pulse width.** `pulse_len`==0 is legal: `out_sig` stays passive and ticks still occur.
- **Counter widths.** `cycle_ctr` is CNT_WIDTH+1 bits; `pulse_ctr` is LEN_WIDTH bits. No counter ever wraps in a normal train.

## Timing
- Start sampled at edge N: `busy` rises and `done_sig` falls after N.
- The first `out_sig` value (p=0) is valid after edge N+1. `out_sig` is registered, so it lags `pulse_ctr` by one edge.
- Pulse k (0-based) is active after edges N+1+k·L+D through N+1+k·L+D+P−1, where L=`cycle_len`, D=`delay`, P=`pulse_len`.
- `cycle_tick` for cycle k is high after edge N+1+k·L+L−1, for one cycle.
- Completion edge is N+1+C·L, where C=`cycle_count`. After it, `done_sig`=1 and `busy`=0.
- Total latency from start edge to `done_sig` high: C·L+1 edges.
- Earliest next accepted `start` is on the edge after `done_sig` rises, so back-to-back trains have one idle cycle between them.
- Rejected start: `cfg_err` is high for the single cycle after edge N.
- `stop` at edge S: `out_sig` passive and `done_sig`=1 after S.
- `rst` mid-run: `out_sig` passive and `done_sig`=0 after the reset edge. `done_sig`=1 one edge after `rst` deasserts.

## Configuration
- Macro `PULSE_TRAIN_CONTINUOUS_EN`.
- **Defined:** `cfg_cycle_count`==0 is valid and means run indefinitely. `cycle_ctr` is not compared and does not increment, and the train ends only on `stop` or `rst`. `cycle_tick` still pulses every cycle.
- **Undefined:** `cfg_cycle_count`==0 is rejected with a `cfg_err` strobe. No continuous-mode logic is synthesised.

## Test plan
- **Basic train.** C=3, L=4, D=1, P=2, ACTIVE_LOW=0, start at edge 10:
  - `out_sig` high after edges 12–13, 16–17, 20–21;
  - `cycle_tick` after edges 14, 18, 22;
  - `done_sig` high after edge 23.
- **Active low.** ACTIVE_LOW=1, C=1, L=3, D=0, P=3: `out_sig` low for exactly 3 cycles, otherwise 1; reset value 1.
- **Config rejection.** Each of L=5,D=3,P=3 / L=0 / C=0 (macro undefined) produces:
  - a one-cycle `cfg_err`;
  - `busy` stays 0 and `done_sig` stays 1.
- **Stop mid-train.** C=10, L=8, `stop` at the 5th RUN edge:
  - `out_sig` passive and `done_sig`=1 after that edge;
  - a subsequent start with C=1 runs normally;
  - `start`+`stop` together in IDLE starts a train.
- **Reset mid-pulse.** `rst` while `out_sig` active:
  - next cycle `out_sig` passive, `done_sig`=0, `busy`=0;
  - `done_sig`=1 one edge after `rst` drops;
  - changing cfg inputs during RUN does not alter the train.
- **Continuous mode.** `PULSE_TRAIN_CONTINUOUS_EN` defined, C=0, L=2, P=1: 100 ticks observed and no done; `stop` terminates the train; P=0 gives a passive output with ticks.

Source files
------------

// File: rtl/pulse_train_generator_if.sv
// Control, configuration and status bundle of pulse_train_generator.
// The master drives start/stop/cfg_*; the slave (generator) drives the status outputs.
interface pulse_train_generator_if #(
  parameter int unsigned CNT_WIDTH = 16,
  parameter int unsigned LEN_WIDTH = 16
);
  logic                 start;
  logic                 stop;
  logic [CNT_WIDTH-1:0] cfg_cycle_count;
  logic [LEN_WIDTH-1:0] cfg_cycle_len;
  logic [LEN_WIDTH-1:0] cfg_pulse_len;
  logic [LEN_WIDTH-1:0] cfg_delay;
  logic                 out_sig;
  logic                 cycle_tick;
  logic                 busy;
  logic                 done_sig;
  logic                 cfg_err;

  modport master (
    output start, stop, cfg_cycle_count, cfg_cycle_len, cfg_pulse_len, cfg_delay,
    input  out_sig, cycle_tick, busy, done_sig, cfg_err
  );

  modport slave (
    input  start, stop, cfg_cycle_count, cfg_cycle_len, cfg_pulse_len, cfg_delay,
    output out_sig, cycle_tick, busy, done_sig, cfg_err
  );
endinterface

// File: rtl/pulse_train_generator.sv
// Runtime-programmable periodic pulse train with abort, status strobes and config checking.
// Define PULSE_TRAIN_CONTINUOUS_EN to let cfg_cycle_count==0 mean "run until stop".
module pulse_train_generator #(
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input logic                   sys_clk,
  input logic                   rst,
  pulse_train_generator_if.slave bus
);
  localparam logic PASSIVE = ACTIVE_LOW;
  localparam logic ACTIVE  = ~ACTIVE_LOW;

  typedef enum logic [1:0] {S_RESET, S_IDLE, S_RUN} state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] plen_q, plen_d;
  logic [LEN_WIDTH-1:0] dly_q, dly_d;
  logic [CNT_WIDTH:0]   cycle_ctr_q, cycle_ctr_d;
  logic [LEN_WIDTH-1:0] pulse_ctr_q, pulse_ctr_d;
  logic                 out_q, out_d;
  logic                 tick_q, tick_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic [LEN_WIDTH:0]   cfg_end;
  logic [LEN_WIDTH:0]   run_end;
  logic                 count_ok;
  logic                 cfg_ok;
  logic                 train_done;
  logic                 cycle_inc;
  logic                 last_phase;
  logic                 in_pulse;

  // Sums carry one extra bit so delay+pulse_len can never wrap past cycle_len.
  assign cfg_end = {1'b0, bus.cfg_delay} + {1'b0, bus.cfg_pulse_len};
  assign run_end = {1'b0, dly_q} + {1'b0, plen_q};

`ifdef PULSE_TRAIN_CONTINUOUS_EN
  assign count_ok   = 1'b1;
  assign train_done = (cnt_q != '0) && (cycle_ctr_q == {1'b0, cnt_q});
  assign cycle_inc  = (cnt_q != '0);
`else
  assign count_ok   = (bus.cfg_cycle_count != '0);
  assign train_done = (cycle_ctr_q == {1'b0, cnt_q});
  assign cycle_inc  = 1'b1;
`endif

  assign cfg_ok     = (bus.cfg_cycle_len != '0) && (cfg_end <= {1'b0, bus.cfg_cycle_len}) && count_ok;
  assign last_phase = (pulse_ctr_q == len_q - LEN_WIDTH'(1));
  assign in_pulse   = (pulse_ctr_q >= dly_q) && ({1'b0, pulse_ctr_q} < run_end);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    plen_d      = plen_q;
    dly_d       = dly_q;
    cycle_ctr_d = cycle_ctr_q;
    pulse_ctr_d = pulse_ctr_q;
    out_d       = PASSIVE;
    tick_d      = 1'b0;
    err_d       = 1'b0;
    busy_d      = busy_q;
    done_d      = done_q;
    unique case (state_q)
      S_RESET: begin
        cycle_ctr_d = '0;
        pulse_ctr_d = '0;
        busy_d      = 1'b0;
        done_d      = 1'b1;
        state_d     = S_IDLE;
      end
      S_IDLE: begin
        busy_d = 1'b0;
        done_d = 1'b1;
        if (bus.start) begin
          cnt_d  = bus.cfg_cycle_count;
          len_d  = bus.cfg_cycle_len;
          plen_d = bus.cfg_pulse_len;
          dly_d  = bus.cfg_delay;
          if (cfg_ok) begin
            cycle_ctr_d = '0;
            pulse_ctr_d = '0;
            busy_d      = 1'b1;
            done_d      = 1'b0;
            state_d     = S_RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        // Abort and completion share one exit path; stop wins over counting.
        if (bus.stop || train_done) begin
          cycle_ctr_d = '0;
          pulse_ctr_d = '0;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          state_d     = S_IDLE;
        end else begin
          out_d = in_pulse ? ACTIVE : PASSIVE;
          if (last_phase) begin
            pulse_ctr_d = '0;
            cycle_ctr_d = cycle_ctr_q + (CNT_WIDTH+1)'(cycle_inc);
            tick_d      = 1'b1;
          end else begin
            pulse_ctr_d = pulse_ctr_q + LEN_WIDTH'(1);
          end
        end
      end
      default: state_d = S_RESET;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q <= S_RESET;
      out_q   <= PASSIVE;
      tick_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      plen_q      <= plen_d;
      dly_q       <= dly_d;
      cycle_ctr_q <= cycle_ctr_d;
      pulse_ctr_q <= pulse_ctr_d;
      out_q       <= out_d;
      tick_q      <= tick_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.out_sig    = out_q;
  assign bus.cycle_tick = tick_q;
  assign bus.busy       = busy_q;
  assign bus.done_sig   = done_q;
  assign bus.cfg_err    = err_q;
endmodule

// File: tb/tb_pulse_train_generator.sv
// Scoreboard bench for pulse_train_generator: stimulus pushes a per-train summary
// derived from the timing rules; a monitor measures each train or rejection and compares.
`timescale 1ns/1ps
module tb_pulse_train_generator;
  localparam int unsigned CW = 16;
  localparam int unsigned LW = 16;
`ifdef PULSE_TRAIN_CONTINUOUS_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pulse_train_generator_if #(.CNT_WIDTH(CW), .LEN_WIDTH(LW)) bus ();
  pulse_train_generator_if #(.CNT_WIDTH(CW), .LEN_WIDTH(LW)) bus_al ();

  pulse_train_generator #(.CNT_WIDTH(CW), .LEN_WIDTH(LW), .ACTIVE_LOW(1'b0)) dut (
    .sys_clk(clk), .rst(rst), .bus(bus)
  );
  pulse_train_generator #(.CNT_WIDTH(CW), .LEN_WIDTH(LW), .ACTIVE_LOW(1'b1)) dut_al (
    .sys_clk(clk), .rst(rst), .bus(bus_al)
  );

  typedef struct {
    bit reject;
    int blen;
    int nact;
    int sact;
    int ntick;
    int stick;
  } exp_t;

  exp_t expq[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // t counts samples after the start edge: t=0 is the first busy cycle with out passive,
  // t>=1 shows phase (t-1) mod L. stop at the k-th run edge leaves exactly k busy samples.
  function automatic exp_t model(input int c, input int l, input int d, input int p, input int k);
    exp_t e;
    int   full;
    e = '{default: 0};
    if (l == 0 || d + p > l || (c == 0 && !CONT)) begin
      e.reject = 1'b1;
      return e;
    end
    full   = (c == 0) ? 32'h4000_0000 : c * l + 1;
    e.blen = (k > 0 && k < full) ? k : full;
    for (int t = 1; t < e.blen; t++) begin
      int ph;
      ph = (t - 1) % l;
      if (ph >= d && ph < d + p) begin
        e.nact++;
        e.sact += t;
      end
      if (ph == l - 1) begin
        e.ntick++;
        e.stick += t;
      end
    end
    return e;
  endfunction

  task automatic drive_train(input int c, input int l, input int d, input int p,
                             input int k, input bit with_stop);
    exp_t e;
    int   waited;
    @(negedge clk);
    bus.cfg_cycle_count = CW'(c);
    bus.cfg_cycle_len   = LW'(l);
    bus.cfg_delay       = LW'(d);
    bus.cfg_pulse_len   = LW'(p);
    bus.start           = 1'b1;
    bus.stop            = with_stop;
    e = model(c, l, d, p, k);
    expq.push_back(e);
    @(negedge clk);
    bus.start           = 1'b0;
    bus.stop            = 1'b0;
    bus.cfg_cycle_count = CW'($urandom);
    bus.cfg_cycle_len   = LW'($urandom);
    bus.cfg_delay       = LW'($urandom);
    bus.cfg_pulse_len   = LW'($urandom);
    if (k > 0 && !e.reject) begin
      repeat (k - 1) @(negedge clk);
      bus.stop = 1'b1;
      @(negedge clk);
      bus.stop = 1'b0;
    end
    waited = 0;
    while (!(bus.done_sig && !bus.busy) && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 3000) begin
      checks++;
      failures++;
      $display("FAIL train_timeout: waited %0d cycles, required done_sig within 3000", waited);
    end
    @(negedge clk);
  endtask

  initial begin : monitor
    bit   rec;
    bit   prev_err;
    int   t, nact, sact, ntick, stick;
    exp_t e;
    rec = 1'b0;
    prev_err = 1'b0;
    t = 0; nact = 0; sact = 0; ntick = 0; stick = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        rec      = 1'b0;
        prev_err = 1'b0;
      end else begin
        if (bus.busy && !rec) begin
          rec = 1'b1;
          t = 0; nact = 0; sact = 0; ntick = 0; stick = 0;
        end
        if (rec && bus.busy) begin
          if (bus.out_sig)    begin nact++;  sact  += t; end
          if (bus.cycle_tick) begin ntick++; stick += t; end
          t++;
        end else if (rec) begin
          rec = 1'b0;
          if (expq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_train: got a train of %0d busy cycles, required none", t);
          end else begin
            e = expq.pop_front();
            chk("train_rejected", e.reject, 0);
            chk("busy_len", t, e.blen);
            chk("active_count", nact, e.nact);
            chk("active_pos_sum", sact, e.sact);
            chk("tick_count", ntick, e.ntick);
            chk("tick_pos_sum", stick, e.stick);
            chk("done_at_end", bus.done_sig, 1);
            chk("out_passive_at_end", bus.out_sig, 0);
            chk("tick_low_at_end", bus.cycle_tick, 0);
          end
        end
        if (bus.cfg_err) begin
          if (expq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_cfg_err: got cfg_err=1, required 0");
          end else begin
            e = expq.pop_front();
            chk("reject_expected", bus.cfg_err, e.reject);
            chk("reject_busy", bus.busy, 0);
            chk("reject_done", bus.done_sig, 1);
          end
        end
        if (prev_err) chk("cfg_err_one_cycle", bus.cfg_err, 0);
        prev_err = bus.cfg_err;
      end
    end
  end

  initial begin : stimulus
    int c, l, d, p, k, lows;
    bus.start = 1'b0; bus.stop = 1'b0;
    bus.cfg_cycle_count = '0; bus.cfg_cycle_len = '0; bus.cfg_delay = '0; bus.cfg_pulse_len = '0;
    bus_al.start = 1'b0; bus_al.stop = 1'b0;
    bus_al.cfg_cycle_count = '0; bus_al.cfg_cycle_len = '0;
    bus_al.cfg_delay = '0; bus_al.cfg_pulse_len = '0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out", bus.out_sig, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done_sig, 0);
    chk("rst_tick", bus.cycle_tick, 0);
    chk("rst_err", bus.cfg_err, 0);
    chk("rst_out_al", bus_al.out_sig, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("done_after_rst", bus.done_sig, 1);
    chk("done_after_rst_al", bus_al.done_sig, 1);

    drive_train(3, 4, 1, 2, 0, 1'b0);
    drive_train(1, 5, 3, 3, 0, 1'b0);
    drive_train(1, 0, 0, 0, 0, 1'b0);
`ifndef PULSE_TRAIN_CONTINUOUS_EN
    drive_train(0, 4, 0, 1, 0, 1'b0);
`endif
    drive_train(10, 8, 2, 3, 5, 1'b0);
    drive_train(1, 8, 2, 3, 0, 1'b0);
    drive_train(2, 3, 0, 1, 0, 1'b1);
    drive_train(2, 5, 2, 3, 0, 1'b0);
    drive_train(3, 4, 1, 0, 0, 1'b0);
    drive_train(4, 1, 0, 1, 0, 1'b0);
    drive_train(2, 1, 0, 0, 0, 1'b0);
`ifdef PULSE_TRAIN_CONTINUOUS_EN
    drive_train(0, 2, 0, 1, 201, 1'b0);
    drive_train(0, 2, 1, 0, 10, 1'b0);
`endif

    // Active-low instance: C=1, L=3, D=0, P=3
    @(negedge clk);
    bus_al.cfg_cycle_count = CW'(1);
    bus_al.cfg_cycle_len   = LW'(3);
    bus_al.cfg_delay       = LW'(0);
    bus_al.cfg_pulse_len   = LW'(3);
    bus_al.start = 1'b1;
    @(negedge clk);
    bus_al.start = 1'b0;
    chk("al_first_passive", bus_al.out_sig, 1);
    lows = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus_al.out_sig == 1'b0) lows++;
    end
    chk("al_low_cycles", lows, 3);
    chk("al_idle_level", bus_al.out_sig, 1);
    chk("al_done", bus_al.done_sig, 1);

    // Reset while the pulse is active: C=5, L=6, D=2, P=3
    @(negedge clk);
    bus.cfg_cycle_count = CW'(5);
    bus.cfg_cycle_len   = LW'(6);
    bus.cfg_delay       = LW'(2);
    bus.cfg_pulse_len   = LW'(3);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pulse_active_before_rst", bus.out_sig, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_out", bus.out_sig, 0);
    chk("midrst_done", bus.done_sig, 0);
    chk("midrst_busy", bus.busy, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_done_after", bus.done_sig, 1);
    chk("midrst_busy_after", bus.busy, 0);

    for (int n = 0; n < 40; n++) begin
      c = int'($urandom_range(1, 4));
      l = int'($urandom_range(0, 6));
      d = int'($urandom_range(0, l));
      p = int'($urandom_range(0, l));
      k = 0;
      if (l > 0 && $urandom_range(0, 3) == 0) k = int'($urandom_range(1, c * l));
      drive_train(c, l, d, p, k, 1'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
